// File: rtl/pit_ctrl.sv
// pit_ctrl: open/close animation sequencer for one floor pit hazard.
// Width grows or shrinks by STEP pixels every TICK_DIV clocks; death
// snaps the floor back to solid in one cycle without a done pulse.
//
// Handshake: open_req/close_req are single-cycle pulses with no ready;
// a pulse is either acted on in the cycle it is high (accepted) or
// dropped, depending on the state. done is a one-cycle completion pulse.
module pit_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int STEP      = 2,
    parameter int PIT_W_MAX = 80,
    parameter int X_MAX     = 639
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       open_req,
    input  logic       close_req,
    input  logic       death,
    input  logic [9:0] pit_x_in,
    input  logic [9:0] target_w,
    output logic [9:0] pit_x,
    output logic [9:0] pit_w,
    output logic       busy,
    output logic       opened,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]  tgt_q, tgt_n;     // open target in OPENING, floor in CLOSING
    logic [9:0]  pit_x_n, pit_w_n;
    logic        done_n;
    logic        tick;
    logic [10:0] room, req_tgt, up_w, dn_w;

    assign dbg_state = state;

    // Requested width clamped to the limit and to the visible screen edge.
    always_comb begin
        room    = 11'(X_MAX + 1) - {1'b0, pit_x_in};
        req_tgt = {1'b0, target_w};
        if (req_tgt > 11'(PIT_W_MAX)) req_tgt = 11'(PIT_W_MAX);
        if (req_tgt > room)           req_tgt = room;
        if ({1'b0, pit_x_in} > 11'(X_MAX)) req_tgt = 11'd0;
    end

    // Stepped widths, 11 bits wide so neither direction can wrap.
    always_comb begin
        up_w = {1'b0, pit_w} + 11'(STEP);
        if (up_w > {1'b0, tgt_q}) up_w = {1'b0, tgt_q};
        if ({1'b0, pit_w} >= {1'b0, tgt_q} + 11'(STEP))
            dn_w = {1'b0, pit_w} - 11'(STEP);
        else
            dn_w = {1'b0, tgt_q};
    end

    assign tick = (state == OPENING || state == CLOSING) &&
                  (cnt == CW'(TICK_DIV - 1));

    // Next-state, next-geometry and completion-pulse logic.
    always_comb begin
        state_n = state;
        pit_x_n = pit_x;
        pit_w_n = pit_w;
        tgt_n   = tgt_q;
        done_n  = 1'b0;
        if (state == OPENING || state == CLOSING)
            cnt_n = tick ? '0 : cnt + CW'(1);
        else
            cnt_n = '0;

        if (death) begin
            state_n = IDLE;
            pit_w_n = 10'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (open_req) begin
                        pit_x_n = pit_x_in;
                        cnt_n   = '0;
                        tgt_n   = req_tgt[9:0];
                        if (req_tgt != 11'd0) state_n = OPENING;
                        else                  done_n  = 1'b1;
                    end
                end
                OPENING: begin
                    if (close_req) begin
                        state_n = CLOSING;
                        tgt_n   = 10'd0;
                        cnt_n   = '0;
                    end else if (tick) begin
                        pit_w_n = up_w[9:0];
                        if (up_w == {1'b0, tgt_q}) begin
                            state_n = OPEN;
                            done_n  = 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (close_req) begin
                        state_n = CLOSING;
                        tgt_n   = 10'd0;
                        cnt_n   = '0;
                    end else if (open_req) begin
                        pit_x_n = pit_x_in;
                        cnt_n   = '0;
                        tgt_n   = req_tgt[9:0];
                        if (req_tgt > {1'b0, pit_w})      state_n = OPENING;
                        else if (req_tgt < {1'b0, pit_w}) state_n = CLOSING;
                        else                              done_n  = 1'b1;
                    end
                end
                CLOSING: begin
                    if (tick) begin
                        pit_w_n = dn_w[9:0];
                        if (dn_w == {1'b0, tgt_q}) begin
                            state_n = (tgt_q == 10'd0) ? IDLE : OPEN;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers; status flags are registered from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tgt_q  <= 10'd0;
            pit_x  <= 10'd0;
            pit_w  <= 10'd0;
            busy   <= 1'b0;
            opened <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tgt_q  <= tgt_n;
            pit_x  <= pit_x_n;
            pit_w  <= pit_w_n;
            busy   <= (state_n == OPENING) || (state_n == CLOSING);
            opened <= (state_n == OPEN);
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_pit_ctrl.sv
// Bench for pit_ctrl with TICK_DIV=4, STEP=2: table of open targets with
// hand-computed clamped widths, plus directed death/retarget/reset cases.
module tb_pit_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       open_req, close_req, death;
    logic [9:0] pit_x_in, target_w;
    logic [9:0] pit_x, pit_w;
    logic       busy, opened, done;
    logic [1:0] dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] tw;
        logic [9:0] exp_w;
    } open_vec_t;

    open_vec_t vecs[7];

    pit_ctrl #(.TICK_DIV(4), .STEP(2), .PIT_W_MAX(80), .X_MAX(639)) dut (
        .clk(clk), .reset(reset), .open_req(open_req), .close_req(close_req),
        .death(death), .pit_x_in(pit_x_in), .target_w(target_w),
        .pit_x(pit_x), .pit_w(pit_w), .busy(busy), .opened(opened),
        .done(done), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One-cycle request pulse; returns just after the accepting edge.
    task automatic pulse(input logic o, input logic c, input logic [9:0] x, input logic [9:0] tw);
        @(negedge clk);
        open_req = o; close_req = c; pit_x_in = x; target_w = tw;
        @(negedge clk);
        open_req = 1'b0; close_req = 1'b0;
    endtask

    // Follows a sequence from w_start to w_end, checking every cycle.
    task automatic follow(input int w_start, input int w_end, input logic end_open);
        int w;
        w = w_start;
        chk("busy_after_accept", busy, 1);
        chk("w_after_accept", pit_w, w);
        chk("done_after_accept", done, 0);
        while (w != w_end) begin
            for (int k = 1; k <= 4; k++) begin
                if (k == 4) begin
                    if (w < w_end) w = (w + 2 > w_end) ? w_end : w + 2;
                    else           w = (w - 2 < w_end) ? w_end : w - 2;
                end
                @(negedge clk);
                chk("step_w", pit_w, w);
                if (k == 4 && w == w_end) begin
                    chk("end_done", done, 1);
                    chk("end_busy", busy, 0);
                    chk("end_opened", opened, end_open);
                end else begin
                    chk("mid_busy", busy, 1);
                    chk("mid_done", done, 0);
                end
            end
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("hold_opened", opened, end_open);
        chk("hold_w", pit_w, w_end);
    endtask

    initial begin
        vecs[0] = '{x: 10'd100, tw: 10'd6,   exp_w: 10'd6};
        vecs[1] = '{x: 10'd100, tw: 10'd200, exp_w: 10'd80};
        vecs[2] = '{x: 10'd620, tw: 10'd50,  exp_w: 10'd20};
        vecs[3] = '{x: 10'd100, tw: 10'd7,   exp_w: 10'd7};
        vecs[4] = '{x: 10'd639, tw: 10'd10,  exp_w: 10'd1};
        vecs[5] = '{x: 10'd640, tw: 10'd10,  exp_w: 10'd0};
        vecs[6] = '{x: 10'd100, tw: 10'd0,   exp_w: 10'd0};

        open_req = 0; close_req = 0; death = 0; pit_x_in = 0; target_w = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pit_w", pit_w, 0);
        chk("rst_pit_x", pit_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_opened", opened, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;

        // Table: open to clamped width, then close back to 0
        for (int i = 0; i < 7; i++) begin
            pulse(1, 0, vecs[i].x, vecs[i].tw);
            chk("latch_x", pit_x, vecs[i].x);
            if (vecs[i].exp_w == 0) begin
                chk("zero_done", done, 1);
                chk("zero_busy", busy, 0);
                chk("zero_w", pit_w, 0);
                @(negedge clk);
                chk("zero_done_drop", done, 0);
                chk("zero_state", dbg_state, 0);
            end else begin
                follow(0, vecs[i].exp_w, 1);
                pulse(0, 1, 10'd0, 10'd0);
                follow(vecs[i].exp_w, 0, 0);
            end
        end

        // Death mid-OPENING at width 4
        pulse(1, 0, 10'd100, 10'd6);
        repeat (8) @(negedge clk);
        chk("pre_death_w", pit_w, 4);
        death = 1'b1;
        @(negedge clk);
        chk("death_w", pit_w, 0);
        chk("death_busy", busy, 0);
        chk("death_done", done, 0);
        chk("death_opened", opened, 0);
        chk("death_state", dbg_state, 0);
        chk("death_x_hold", pit_x, 100);
        death = 1'b0;
        @(negedge clk);
        chk("post_death_done", done, 0);

        // Restart with full first step, then retarget down to 2
        pulse(1, 0, 10'd200, 10'd6);
        follow(0, 6, 1);
        pulse(1, 0, 10'd200, 10'd2);
        follow(6, 2, 1);
        chk("retarget_state", dbg_state, 2);

        // open+close together in OPEN: close wins
        pulse(1, 1, 10'd300, 10'd80);
        follow(2, 0, 0);
        chk("close_wins_x", pit_x, 200);

        // open+close together in IDLE: open wins
        pulse(1, 1, 10'd50, 10'd4);
        follow(0, 4, 1);

        // Async reset between edges during CLOSING
        pulse(0, 1, 10'd0, 10'd0);
        repeat (4) @(negedge clk);
        chk("pre_reset_w", pit_w, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_w", pit_w, 0);
        chk("async_x", pit_x, 0);
        chk("async_busy", busy, 0);
        chk("async_opened", opened, 0);
        chk("async_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
